// File: rtl/servo_bank_pkg.sv
// servo_bank_pkg: shared types and defaults for the servo_bank controller.
// Holds the per-channel state enum, the counter width helper and the default
// timing constants for a 50 MHz system clock.
package servo_bank_pkg;

    typedef enum logic [1:0] {
        CLOSED  = 2'd0,
        OPENING = 2'd1,
        OPEN    = 2'd2,
        CLOSING = 2'd3
    } ch_state_t;

    localparam int DEF_N_CH        = 4;
    localparam int DEF_TICK_DIV    = 5000;
    localparam int DEF_FRAME_TICKS = 200;
    localparam int DEF_PW_MIN      = 10;
    localparam int DEF_PW_MAX      = 20;
    localparam int DEF_STEP_SLOW   = 1;
    localparam int DEF_STEP_FAST   = 2;
    localparam int DEF_IDLE_FRAMES = 50;

    // Width shared by pos and frame_cnt; one spare bit so pos+step cannot wrap
    function automatic int cnt_width(input int frame_ticks);
        return $clog2(frame_ticks) + 1;
    endfunction

endpackage

// File: rtl/servo_ch.sv
// servo_ch: one servo channel -- slewing pulse position, open/close FSM,
// PWM compare against the shared frame counter.
// Optional: SERVO_BANK_IDLE_PARK_EN parks the output after a run of idle
// frames in CLOSED.
module servo_ch import servo_bank_pkg::*; #(
`ifdef SERVO_BANK_IDLE_PARK_EN
    parameter int IDLE_FRAMES = DEF_IDLE_FRAMES,
`endif
    parameter int CW        = 9,
    parameter int PW_MIN    = DEF_PW_MIN,
    parameter int PW_MAX    = DEF_PW_MAX,
    parameter int STEP_SLOW = DEF_STEP_SLOW,
    parameter int STEP_FAST = DEF_STEP_FAST
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wrap,
    input  logic [CW-1:0] frame_cnt,
    input  logic          en,
    input  logic          vel,
    output logic          pwm,
    output logic          busy,
    output logic          at_open
);

    localparam logic [CW-1:0] PMIN_C = CW'(PW_MIN);
    localparam logic [CW-1:0] PMAX_C = CW'(PW_MAX);

    logic [CW-1:0] pos;
    logic [CW-1:0] pos_next;
    logic [CW-1:0] step;
    logic [CW-1:0] sum;
    ch_state_t     state;
    ch_state_t     state_next;
    logic          parked;

    // Saturating slew of the pulse position toward open or closed
    always_comb begin
        step     = vel ? CW'(STEP_FAST) : CW'(STEP_SLOW);
        sum      = pos + step;
        pos_next = pos;
        if (en) begin
            pos_next = (sum >= PMAX_C) ? PMAX_C : sum;
        end else begin
            pos_next = (pos <= PMIN_C + step) ? PMIN_C : pos - step;
        end
    end

    // Next state decided from the freshly slewed position and the sampled en
    always_comb begin
        state_next = state;
        case (state)
            CLOSED: begin
                if (en) begin
                    state_next = (pos_next == PMAX_C) ? OPEN : OPENING;
                end
            end
            OPENING: begin
                if (pos_next == PMAX_C) begin
                    state_next = OPEN;
                end else if (!en) begin
                    state_next = CLOSING;
                end
            end
            OPEN: begin
                if (!en) begin
                    state_next = CLOSING;
                end
            end
            CLOSING: begin
                if (pos_next == PMIN_C) begin
                    state_next = CLOSED;
                end else if (en) begin
                    state_next = OPENING;
                end
            end
            default: state_next = CLOSED;
        endcase
    end

    // Position and state only move on the frame wrap, so pulses stay whole
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos   <= PMIN_C;
            state <= CLOSED;
        end else if (wrap) begin
            pos   <= pos_next;
            state <= state_next;
        end
    end

`ifdef SERVO_BANK_IDLE_PARK_EN
    localparam int IW = $clog2(IDLE_FRAMES + 1);

    logic [IW-1:0] idle_cnt;

    // Count consecutive wraps spent in CLOSED, saturating at the park threshold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (wrap) begin
            if (state_next != CLOSED) begin
                idle_cnt <= '0;
            end else if (state == CLOSED && idle_cnt < IW'(IDLE_FRAMES)) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    assign parked = (state == CLOSED) && (idle_cnt >= IW'(IDLE_FRAMES));
`else
    assign parked = 1'b0;
`endif

    // Registered pulse compare and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm     <= 1'b0;
            busy    <= 1'b0;
            at_open <= 1'b0;
        end else begin
            pwm     <= (frame_cnt < pos) && !parked;
            busy    <= (state == OPENING) || (state == CLOSING);
            at_open <= (state == OPEN);
        end
    end

endmodule

// File: rtl/servo_bank.sv
// servo_bank: N-channel servo PWM controller with internal tick prescaler and
// 20 ms frame counter shared by all channels.
// Optional: SERVO_BANK_IDLE_PARK_EN (idle parking of closed channels).
module servo_bank import servo_bank_pkg::*; #(
    parameter int N_CH        = DEF_N_CH,
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int FRAME_TICKS = DEF_FRAME_TICKS,
    parameter int PW_MIN      = DEF_PW_MIN,
    parameter int PW_MAX      = DEF_PW_MAX,
    parameter int STEP_SLOW   = DEF_STEP_SLOW,
    parameter int STEP_FAST   = DEF_STEP_FAST,
    parameter int IDLE_FRAMES = DEF_IDLE_FRAMES
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] en,
    input  logic [N_CH-1:0] vel,
    output logic [N_CH-1:0] pwm,
    output logic [N_CH-1:0] busy,
    output logic [N_CH-1:0] at_open,
    output logic            frame_start
);

    localparam int CW  = cnt_width(FRAME_TICKS);
    localparam int PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    if (!(PW_MIN > 0 && PW_MIN < PW_MAX && PW_MAX < FRAME_TICKS &&
          STEP_SLOW >= 1 && STEP_FAST >= 1 && TICK_DIV >= 1 &&
          IDLE_FRAMES >= 1)) begin : g_bad_params
        $error("servo_bank: illegal parameter combination");
    end

    logic [PSW-1:0] prescaler;
    logic [CW-1:0]  frame_cnt;
    logic           tick;
    logic           wrap;

    assign tick = (prescaler == PSW'(TICK_DIV - 1));
    assign wrap = tick && (frame_cnt == CW'(FRAME_TICKS - 1));

    // Divide the system clock down to the PWM tick rate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
        end
    end

    // Frame position in ticks, plus a strobe for the clock where it returns to 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt   <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= wrap;
            if (wrap) begin
                frame_cnt <= '0;
            end else if (tick) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        servo_ch #(
`ifdef SERVO_BANK_IDLE_PARK_EN
            .IDLE_FRAMES (IDLE_FRAMES),
`endif
            .CW          (CW),
            .PW_MIN      (PW_MIN),
            .PW_MAX      (PW_MAX),
            .STEP_SLOW   (STEP_SLOW),
            .STEP_FAST   (STEP_FAST)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .wrap      (wrap),
            .frame_cnt (frame_cnt),
            .en        (en[i]),
            .vel       (vel[i]),
            .pwm       (pwm[i]),
            .busy      (busy[i]),
            .at_open   (at_open[i])
        );
    end

endmodule

// File: tb/tb_servo_bank.sv
// tb_servo_bank: directed and randomized frames against a frame-level model
// of servo_bank (pulse widths counted per frame, status flags, frame strobe).
module tb_servo_bank;

    localparam int N          = 4;
    localparam int TD         = 2;
    localparam int FT         = 40;
    localparam int PMIN       = 10;
    localparam int PMAX       = 20;
    localparam int SSLOW      = 1;
    localparam int SFAST      = 2;
    localparam int IDLE       = 3;
    localparam int FRAME_CLKS = TD * FT;

    localparam int M_CLOSED  = 0;
    localparam int M_OPENING = 1;
    localparam int M_OPEN    = 2;
    localparam int M_CLOSING = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] en = '0;
    logic [N-1:0] vel = '0;
    logic [N-1:0] pwm;
    logic [N-1:0] busy;
    logic [N-1:0] at_open;
    logic         frame_start;

    int passed = 0;
    int total  = 0;

    int m_pos[N];
    int m_state[N];
    int m_idle[N];

    always #5 clk = ~clk;

    servo_bank #(
        .N_CH(N), .TICK_DIV(TD), .FRAME_TICKS(FT), .PW_MIN(PMIN),
        .PW_MAX(PMAX), .STEP_SLOW(SSLOW), .STEP_FAST(SFAST), .IDLE_FRAMES(IDLE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .vel(vel), .pwm(pwm),
        .busy(busy), .at_open(at_open), .frame_start(frame_start)
    );

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] e, input logic [N-1:0] v);
        en  = e;
        vel = v;
    endtask

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            m_pos[i]   = PMIN;
            m_state[i] = M_CLOSED;
            m_idle[i]  = 0;
        end
    endtask

    function automatic bit modelParked(input int i);
`ifdef SERVO_BANK_IDLE_PARK_EN
        return (m_state[i] == M_CLOSED) && (m_idle[i] >= IDLE);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int expWidth(input int i);
        return modelParked(i) ? 0 : TD * m_pos[i];
    endfunction

    // One frame wrap: slew every channel and step its open/close behaviour
    task automatic modelWrap();
        int step;
        int np;
        int ns;
        for (int i = 0; i < N; i++) begin
            step = vel[i] ? SFAST : SSLOW;
            if (en[i]) np = (m_pos[i] + step > PMAX) ? PMAX : m_pos[i] + step;
            else       np = (m_pos[i] - step < PMIN) ? PMIN : m_pos[i] - step;
            ns = m_state[i];
            if (m_state[i] == M_CLOSED) begin
                if (en[i]) ns = (np == PMAX) ? M_OPEN : M_OPENING;
            end else if (m_state[i] == M_OPENING) begin
                if (np == PMAX) ns = M_OPEN;
                else if (!en[i]) ns = M_CLOSING;
            end else if (m_state[i] == M_OPEN) begin
                if (!en[i]) ns = M_CLOSING;
            end else begin
                if (np == PMIN) ns = M_CLOSED;
                else if (en[i]) ns = M_OPENING;
            end
            if (ns != M_CLOSED) m_idle[i] = 0;
            else if (m_state[i] == M_CLOSED && m_idle[i] < IDLE) m_idle[i]++;
            m_pos[i]   = np;
            m_state[i] = ns;
        end
    endtask

    // Observe one full frame, then apply the wrap to the model
    task automatic runFrame(input logic [N-1:0] e, input logic [N-1:0] v, input bit glitch);
        int           hi[N];
        int           fs_cnt;
        logic         fs_last;
        logic [N-1:0] exp_busy;
        logic [N-1:0] exp_open;
        fs_cnt  = 0;
        fs_last = 1'b0;
        for (int i = 0; i < N; i++) hi[i] = 0;
        for (int c = 1; c <= FRAME_CLKS; c++) begin
            @(negedge clk);
            if (c == 10) begin
                for (int i = 0; i < N; i++) begin
                    exp_busy[i] = (m_state[i] == M_OPENING) || (m_state[i] == M_CLOSING);
                    exp_open[i] = (m_state[i] == M_OPEN);
                end
                checkOutput("busy", 32'(busy), 32'(exp_busy));
                checkOutput("at_open", 32'(at_open), 32'(exp_open));
                applyStimulus(e, v);
            end
            if (glitch && c == 30) applyStimulus(~e, ~v);
            if (glitch && c == 60) applyStimulus(e, v);
            for (int i = 0; i < N; i++) hi[i] += int'(pwm[i]);
            fs_cnt += int'(frame_start);
            if (c == FRAME_CLKS) fs_last = frame_start;
        end
        for (int i = 0; i < N; i++) begin
            checkOutput($sformatf("pwm_width_ch%0d", i), 32'(hi[i]), 32'(expWidth(i)));
        end
        checkOutput("frame_start_count", 32'(fs_cnt), 32'd1);
        checkOutput("frame_start_at_wrap", 32'(fs_last), 32'd1);
        modelWrap();
    endtask

    initial begin
        logic [N-1:0] exp_hi;
        modelReset();
        applyStimulus('0, '0);
        repeat (3) @(negedge clk);
        checkOutput("reset_pwm", 32'(pwm), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_at_open", 32'(at_open), 32'd0);
        checkOutput("reset_frame_start", 32'(frame_start), 32'd0);
        rst_n = 1'b1;

        $display("[TB] closed frame, then ch0 fast / ch1 slow opening");
        runFrame(4'b0000, 4'b0000, 1'b0);
        repeat (5) runFrame(4'b0011, 4'b0001, 1'b0);

        $display("[TB] ch2 reversal while opening");
        repeat (2) runFrame(4'b0111, 4'b0101, 1'b0);
        runFrame(4'b0011, 4'b0101, 1'b0);
        runFrame(4'b0011, 4'b0101, 1'b1);
        runFrame(4'b0011, 4'b0001, 1'b1);

        $display("[TB] randomized frames");
        for (int f = 0; f < 20; f++) begin
            runFrame(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("[TB] reset asserted mid-pulse");
        repeat (5) @(negedge clk);
        for (int i = 0; i < N; i++) exp_hi[i] = !modelParked(i);
        checkOutput("pwm_before_reset", 32'(pwm), 32'(exp_hi));
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_pwm", 32'(pwm), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_at_open", 32'(at_open), 32'd0);
        modelReset();
        applyStimulus('0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        runFrame(4'b1111, 4'b1010, 1'b0);
        runFrame(4'b1111, 4'b1010, 1'b0);

        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
